// File: rtl/spi_ram_master.sv
// spi_ram_master
//   Command-driven SPI master for the SPI-slave + single-port RAM wrapper.
//   A local read or write request is turned into the wrapper's two-frame
//   protocol:
//     write: {00,addr} frame, then {01,wdata} frame
//     read : {10,addr} frame, then {11,8'h00} frame, then an 8-bit MISO reply
//   Every frame is CS, SEL, 10 SHIFT bits (MSB first), an optional
//   WAIT/RECV phase (read frame 1 only), and GAP_CYCLES cycles with SS_n high.
//
//   Handshake: a command transfers on a rising edge where cmd_valid and
//   cmd_ready are both high. cmd_ready is high only in IDLE. The producer
//   may hold cmd_valid high at any time; it is ignored outside IDLE.
//   rsp_valid is a one-cycle pulse with no back-pressure.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   request handshake
//   cmd_write             1 = write, 0 = read
//   cmd_addr, cmd_wdata   RAM address and write data
//   rsp_valid, rsp_rdata  completion pulse and read data
//   busy                  high from accept through the rsp_valid cycle
//   SS_n, MOSI, MISO      SPI pins toward the wrapper
//   dbg_state             current FSM state, for debug and checkers
module spi_ram_master #(
  parameter int GAP_CYCLES = 1,
  parameter int READ_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [2:0] dbg_state
);

  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CS    = 3'd1,
    S_SEL   = 3'd2,
    S_SHIFT = 3'd3,
    S_WAIT  = 3'd4,
    S_RECV  = 3'd5,
    S_GAP   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t              r_state;
  logic [9:0]          r_frame;
  logic                r_frame_idx;
  logic                r_write;
  logic [7:0]          r_wdata;
  logic [3:0]          r_bit_cnt;
  logic [2:0]          r_recv_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [7:0]          r_shift;
  logic                r_ss_n;
  logic                r_mosi;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic                r_busy;
  logic [7:0]          r_rsp_rdata;

  state_t              w_state_next;
  logic [9:0]          w_frame_next;
  logic                w_frame_idx_next;
  logic [3:0]          w_bit_cnt_next;
  logic [2:0]          w_recv_cnt_next;
  logic [WAIT_W-1:0]   w_wait_cnt_next;
  logic [GAP_W-1:0]    w_gap_cnt_next;
  logic [7:0]          w_shift_next;
  logic                w_accept;
  logic                w_ss_n_next;
  logic                w_mosi_next;

  always_comb begin
    w_state_next     = r_state;
    w_frame_next     = r_frame;
    w_frame_idx_next = r_frame_idx;
    w_bit_cnt_next   = r_bit_cnt;
    w_recv_cnt_next  = r_recv_cnt;
    w_wait_cnt_next  = r_wait_cnt;
    w_gap_cnt_next   = r_gap_cnt;
    w_shift_next     = r_shift;
    w_accept         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept         = 1'b1;
          w_state_next     = S_CS;
          w_frame_idx_next = 1'b0;
          // Frame 0 is built straight from the request inputs.
          w_frame_next     = {~cmd_write, 1'b0, cmd_addr};
        end
      end
      S_CS:  w_state_next = S_SEL;
      S_SEL: begin
        w_state_next   = S_SHIFT;
        w_bit_cnt_next = 4'd0;
      end
      S_SHIFT: begin
        if (r_bit_cnt == 4'd9) begin
          if (!r_write && r_frame_idx) begin
            w_state_next    = S_WAIT;
            w_wait_cnt_next = '0;
          end else begin
            w_state_next   = S_GAP;
            w_gap_cnt_next = '0;
          end
        end else begin
          w_bit_cnt_next = r_bit_cnt + 4'd1;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == WAIT_W'(READ_LAT - 1)) begin
          w_state_next    = S_RECV;
          w_recv_cnt_next = 3'd0;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end
      S_RECV: begin
        w_shift_next = {r_shift[6:0], MISO};
        if (r_recv_cnt == 3'd7) begin
          w_state_next   = S_GAP;
          w_gap_cnt_next = '0;
        end else begin
          w_recv_cnt_next = r_recv_cnt + 3'd1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          if (!r_frame_idx) begin
            w_state_next     = S_CS;
            w_frame_idx_next = 1'b1;
            w_frame_next     = r_write ? {2'b01, r_wdata} : {2'b11, 8'h00};
          end else begin
            w_state_next = S_DONE;
          end
        end else begin
          w_gap_cnt_next = r_gap_cnt + 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pin values are computed for the upcoming state so that they can be
  // registered and still line up with that state's cycle.
  always_comb begin
    w_ss_n_next = 1'b1;
    w_mosi_next = 1'b0;
    case (w_state_next)
      S_CS, S_WAIT, S_RECV: w_ss_n_next = 1'b0;
      S_SEL: begin
        w_ss_n_next = 1'b0;
        w_mosi_next = r_frame[9];
      end
      S_SHIFT: begin
        w_ss_n_next = 1'b0;
        w_mosi_next = r_frame[4'd9 - w_bit_cnt_next];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_frame     <= '0;
      r_frame_idx <= 1'b0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_bit_cnt   <= '0;
      r_recv_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_shift     <= '0;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_frame     <= w_frame_next;
      r_frame_idx <= w_frame_idx_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_recv_cnt  <= w_recv_cnt_next;
      r_wait_cnt  <= w_wait_cnt_next;
      r_gap_cnt   <= w_gap_cnt_next;
      r_shift     <= w_shift_next;
      if (w_accept) begin
        r_write <= cmd_write;
        r_wdata <= cmd_wdata;
      end
      r_ss_n      <= w_ss_n_next;
      r_mosi      <= w_mosi_next;
      r_cmd_ready <= (w_state_next == S_IDLE);
      r_busy      <= (w_state_next != S_IDLE);
      r_rsp_valid <= (w_state_next == S_DONE);
      // The reply is complete by GAP, so r_shift is final when DONE is entered.
      if (w_state_next == S_DONE && !r_write) r_rsp_rdata <= r_shift;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = r_busy;
  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_ram_master.sv
// Testbench for spi_ram_master. The bench plays the SPI slave: it keeps a RAM
// image, drives the read reply on MISO in the reply window and random noise
// elsewhere, and compares every pin against a cycle table built from the
// frame words of each request.
module tb_spi_ram_master;

  localparam int G = 1;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [256];
  logic [7:0] last_rdata = 8'h00;
  logic [7:0] exp_q [$];

  spi_ram_master #(.GAP_CYCLES(G), .READ_LAT(R)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // One request from accept to the first IDLE cycle after DONE.
  // hold   : keep cmd_valid high through the operation
  // rst_at : nonzero -> assert rst at the end of that cycle and abort
  task automatic do_op(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                       input logic hold, input int rst_at);
    bit q_ss[$];
    bit q_mosi[$];
    bit q_mchk[$];
    logic [9:0] fw;
    logic [7:0] rd_val;
    logic [7:0] exp_val;
    int len;
    int k0;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) fw = {wr ? 2'b00 : 2'b10, addr};
      else        fw = wr ? {2'b01, wd} : {2'b11, 8'h00};
      q_ss.push_back(1'b0); q_mosi.push_back(1'b0);  q_mchk.push_back(1'b1);   // CS
      q_ss.push_back(1'b0); q_mosi.push_back(fw[9]); q_mchk.push_back(1'b1);   // SEL
      for (int j = 9; j >= 0; j--) begin
        q_ss.push_back(1'b0); q_mosi.push_back(fw[j]); q_mchk.push_back(1'b1);
      end
      if (!wr && f == 1) begin
        for (int i = 0; i < R; i++) begin
          q_ss.push_back(1'b0); q_mosi.push_back(1'b0); q_mchk.push_back(1'b1);
        end
        for (int i = 0; i < 8; i++) begin
          q_ss.push_back(1'b0); q_mosi.push_back(1'b0); q_mchk.push_back(1'b0);
        end
      end
      for (int i = 0; i < G; i++) begin
        q_ss.push_back(1'b1); q_mosi.push_back(1'b0); q_mchk.push_back(1'b1);
      end
    end
    q_ss.push_back(1'b1); q_mosi.push_back(1'b0); q_mchk.push_back(1'b1);     // DONE
    len = q_ss.size();
    k0 = (12 + G) + 12 + R + 1;
    rd_val = mem[addr];
    exp_val = wr ? last_rdata : rd_val;
    exp_q.push_back(exp_val);

    check_val("ready_pre", 8'(cmd_ready), 8'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) begin
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
      end
      if (rst_at != 0 && k == rst_at + 1) begin
        check_val("abort_ss_n", 8'(SS_n), 8'd1);
        check_val("abort_mosi", 8'(MOSI), 8'd0);
        check_val("abort_ready", 8'(cmd_ready), 8'd1);
        check_val("abort_busy", 8'(busy), 8'd0);
        check_val("abort_rsp_valid", 8'(rsp_valid), 8'd0);
        check_val("abort_rdata", rsp_rdata, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          check_val("abort_no_rsp", 8'(rsp_valid), 8'd0);
          check_val("abort_idle_ss", 8'(SS_n), 8'd1);
        end
        exp_q.delete();
        last_rdata = 8'h00;
        return;
      end
      if (k <= len) begin
        check_val($sformatf("ss_n_c%0d", k), 8'(SS_n), 8'(q_ss[k-1]));
        if (q_mchk[k-1]) check_val($sformatf("mosi_c%0d", k), 8'(MOSI), 8'(q_mosi[k-1]));
        check_val($sformatf("busy_c%0d", k), 8'(busy), 8'd1);
        check_val($sformatf("ready_c%0d", k), 8'(cmd_ready), 8'd0);
        check_val($sformatf("rsp_valid_c%0d", k), 8'(rsp_valid), 8'(k == len));
      end else begin
        check_val("post_ss_n", 8'(SS_n), 8'd1);
        check_val("post_mosi", 8'(MOSI), 8'd0);
        check_val("post_busy", 8'(busy), 8'd0);
        check_val("post_ready", 8'(cmd_ready), 8'd1);
        check_val("post_rsp_valid", 8'(rsp_valid), 8'd0);
        check_val("post_rdata", rsp_rdata, exp_val);
      end
      if (rsp_valid && exp_q.size() > 0) check_val("rsp_rdata", rsp_rdata, exp_q.pop_front());
      if (hold && k == len) cmd_valid = 1'b0;
      if (rst_at != 0 && k == rst_at) begin
        rst = 1'b1;
        cmd_valid = 1'b0;
      end
      MISO = (!wr && k >= k0 && k < k0 + 8) ? rd_val[7 - (k - k0)] : 1'($urandom_range(0, 1));
    end
    if (wr) mem[addr] = wd;
    last_rdata = exp_val;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'hAA] = 8'hA5;

    // reset block
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ss_n", 8'(SS_n), 8'd1);
    check_val("rst_mosi", 8'(MOSI), 8'd0);
    check_val("rst_ready", 8'(cmd_ready), 8'd1);
    check_val("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    check_val("rst_busy", 8'(busy), 8'd0);
    check_val("rst_rdata", rsp_rdata, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle_ready", 8'(cmd_ready), 8'd1);

    // directed cases
    do_op(1'b1, 8'h55, 8'hFF, 1'b0, 0);   // write, rdata stays 00
    do_op(1'b0, 8'hAA, 8'h00, 1'b0, 0);   // read A5
    do_op(1'b0, 8'h55, 8'h00, 1'b0, 0);   // read back FF
    do_op(1'b1, 8'h12, 8'h3C, 1'b1, 0);   // cmd_valid held high
    do_op(1'b0, 8'h12, 8'h00, 1'b1, 0);
    do_op(1'b1, 8'h33, 8'h5A, 1'b0, 18);  // reset in frame1 SHIFT
    do_op(1'b0, 8'h33, 8'h00, 1'b0, 0);   // old contents, write was aborted

    // randomized operations, some back-to-back
    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
